// File: rtl/cve2_mem_arbiter.sv
// Round-robin arbiter that merges the cve2 fetch and LSU OBI ports onto one memory port.
// Responses are routed back in order through a small outstanding-transaction FIFO.
module cve2_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        unexp_rsp_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic {
        SEL_INSTR = 1'b0,
        SEL_DATA  = 1'b1
    } sel_e;

    sel_e                    sel;
    sel_e                    last_q;
    sel_e                    locked_sel_q;
    logic                    lock_q;
    logic [MaxOutstanding-1:0] fifo_q;
    logic [PtrW-1:0]         wptr_q;
    logic [PtrW-1:0]         rptr_q;
    logic [CntW-1:0]         cnt_q;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic                    head;
    logic                    unexp_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxOutstanding - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // Master selection: a pending ungranted address phase holds its master.
    always_comb begin
        sel = SEL_INSTR;
        if (lock_q) begin
            sel = locked_sel_q;
        end else if (instr_req_i && data_req_i) begin
            sel = (last_q == SEL_INSTR) ? SEL_DATA : SEL_INSTR;
        end else if (data_req_i) begin
            sel = SEL_DATA;
        end
    end

    assign full = (cnt_q == CntW'(MaxOutstanding));
    assign mem_req_o = (instr_req_i | data_req_i) & ~full;
    assign push = mem_req_o & mem_gnt_i;
    assign pop = mem_rvalid_i & (cnt_q != '0);
    assign head = fifo_q[rptr_q];

    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = '0;
        if (sel == SEL_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign instr_gnt_o = push & (sel == SEL_INSTR);
    assign data_gnt_o  = push & (sel == SEL_DATA);

    assign instr_rvalid_o = pop & ~head;
    assign data_rvalid_o  = pop & head;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i & instr_rvalid_o;
    assign data_err_o     = mem_err_i & data_rvalid_o;
    assign unexp_rsp_o    = unexp_q;

    // Arbitration history and address-phase lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q       <= SEL_INSTR;
            lock_q       <= 1'b0;
            locked_sel_q <= SEL_INSTR;
        end else begin
            if (push) begin
                last_q <= sel;
            end
            if (mem_req_o) begin
                lock_q       <= ~mem_gnt_i;
                locked_sel_q <= sel;
            end
        end
    end

    // In-order record of which master owns each outstanding transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            unexp_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= (sel == SEL_DATA);
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
            if (mem_rvalid_i && (cnt_q == '0)) begin
                unexp_q <= 1'b1;
            end
        end
    end

endmodule
